// File: rtl/vga_stream_pkg.sv
// Shared timing constants and pixel-unpack helper for the VGA pixel stream.
// Default raster is 1280x1024@60; the FIFO word carries four 32-bit pixel lanes.
package vga_stream_pkg;

    localparam int unsigned DEF_IMAGE_WIDTH  = 1280;
    localparam int unsigned DEF_IMAGE_HEIGHT = 1024;
    localparam int unsigned DEF_H_FRONT      = 48;
    localparam int unsigned DEF_H_SYNC       = 112;
    localparam int unsigned DEF_H_BACK       = 248;
    localparam int unsigned DEF_V_FRONT      = 1;
    localparam int unsigned DEF_V_SYNC       = 3;
    localparam int unsigned DEF_V_BACK       = 38;

    localparam int unsigned PIX_PER_WORD = 4;
    localparam int unsigned PIX_BITS     = 32;
    localparam int unsigned WORD_BITS    = PIX_PER_WORD * PIX_BITS;
    localparam int unsigned RGB_BITS     = 24;
    localparam int unsigned DEBT_BITS    = 16;

    localparam logic [DEBT_BITS-1:0] DEBT_MAX = '1;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_SHOW,
        SLOT_UNDERFLOW,
        SLOT_DISCARD
    } slot_kind_e;

    function automatic logic [RGB_BITS-1:0] unpack_rgb(
        input logic [WORD_BITS-1:0] word,
        input logic [1:0]           lane
    );
        return word[int'(lane) * PIX_BITS +: RGB_BITS];
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters and sync/active/frame-start decode; outputs are combinational
// from the counter state so the consumer can register everything in one stage.
module vga_timing_gen
    import vga_stream_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int unsigned IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int unsigned H_FRONT      = DEF_H_FRONT,
    parameter int unsigned H_SYNC       = DEF_H_SYNC,
    parameter int unsigned H_BACK       = DEF_H_BACK,
    parameter int unsigned V_FRONT      = DEF_V_FRONT,
    parameter int unsigned V_SYNC       = DEF_V_SYNC,
    parameter int unsigned V_BACK       = DEF_V_BACK
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [1:0] lane_o,
    output logic       active_o,
    output logic       hs_o,
    output logic       vs_o,
    output logic       frame_start_o
);

    localparam int unsigned H_TOT = IMAGE_WIDTH + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOT = IMAGE_HEIGHT + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HCW   = $clog2(H_TOT);
    localparam int unsigned VCW   = $clog2(V_TOT);

    localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOT - 1);
    localparam logic [HCW-1:0] H_ACT      = HCW'(IMAGE_WIDTH);
    localparam logic [HCW-1:0] HS_START   = HCW'(IMAGE_WIDTH + H_FRONT);
    localparam logic [HCW-1:0] HS_END     = HCW'(IMAGE_WIDTH + H_FRONT + H_SYNC);
    localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOT - 1);
    localparam logic [VCW-1:0] V_ACT      = VCW'(IMAGE_HEIGHT);
    localparam logic [VCW-1:0] VS_START   = VCW'(IMAGE_HEIGHT + V_FRONT);
    localparam logic [VCW-1:0] VS_END     = VCW'(IMAGE_HEIGHT + V_FRONT + V_SYNC);

    logic [HCW-1:0] h_q;
    logic [VCW-1:0] v_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_q == H_LAST) begin
            h_q <= '0;
            v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            h_q <= h_q + 1'b1;
        end
    end

    assign lane_o        = h_q[1:0];
    assign active_o      = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_o          = (h_q >= HS_START) && (h_q < HS_END);
    assign vs_o          = (v_q >= VS_START) && (v_q < VS_END);
    assign frame_start_o = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_pixel_stream.sv
// VGA output stage: pops one 128-bit FIFO word per four active pixels, unpacks RGB,
// and tracks words owed after an underflow so the stream realigns to word boundaries.
module vga_pixel_stream
    import vga_stream_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int unsigned IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int unsigned H_FRONT      = DEF_H_FRONT,
    parameter int unsigned H_SYNC       = DEF_H_SYNC,
    parameter int unsigned H_BACK       = DEF_H_BACK,
    parameter int unsigned V_FRONT      = DEF_V_FRONT,
    parameter int unsigned V_SYNC       = DEF_V_SYNC,
    parameter int unsigned V_BACK       = DEF_V_BACK
) (
    input  logic                 vga_clk,
    input  logic                 vga_reset_n,
    input  logic                 stream_en,
    input  logic                 data_fifo_empty,
    input  logic [WORD_BITS-1:0] data_fifo_rd_data,
    output logic                 vga_rd_valid,
    output logic [7:0]           vga_r,
    output logic [7:0]           vga_g,
    output logic [7:0]           vga_b,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic                 vga_blank_n,
    output logic                 frame_start,
    output logic                 underflow,
    input  logic                 underflow_clr
);

    logic [1:0] lane;
    logic       active, hs, vs, fs;

    vga_timing_gen #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT),
        .H_FRONT      (H_FRONT),
        .H_SYNC       (H_SYNC),
        .H_BACK       (H_BACK),
        .V_FRONT      (V_FRONT),
        .V_SYNC       (V_SYNC),
        .V_BACK       (V_BACK)
    ) u_timing (
        .clk_i         (vga_clk),
        .rst_ni        (vga_reset_n),
        .lane_o        (lane),
        .active_o      (active),
        .hs_o          (hs),
        .vs_o          (vs),
        .frame_start_o (fs)
    );

    logic                 frame_en_q, frame_en;
    logic [DEBT_BITS-1:0] debt_q, debt_d;
    logic [WORD_BITS-1:0] pix_word_q;
    logic                 show_q;
    logic                 underflow_q;
    logic [RGB_BITS-1:0]  rgb_q, rgb_d;
    logic                 hs_q, vs_q, blank_n_q, fs_q;
    logic                 slot, pop, uf_set;
    slot_kind_e           kind;

    // The first slot of a frame sits on the sampling cycle itself, so it sees stream_en directly.
    assign frame_en = fs ? stream_en : frame_en_q;
    assign slot     = active && (lane == 2'd0) && frame_en;

    always_comb begin
        kind   = SLOT_IDLE;
        pop    = 1'b0;
        uf_set = 1'b0;
        debt_d = debt_q;
        if (slot) begin
            if (data_fifo_empty) begin
                kind   = SLOT_UNDERFLOW;
                uf_set = 1'b1;
                if (debt_q != DEBT_MAX) debt_d = debt_q + 1'b1;
            end else if (debt_q != '0) begin
                kind   = SLOT_DISCARD;
                pop    = 1'b1;
                debt_d = debt_q - 1'b1;
            end else begin
                kind   = SLOT_SHOW;
                pop    = 1'b1;
            end
        end else if (frame_en && !data_fifo_empty && (debt_q != '0)) begin
            pop    = 1'b1;
            debt_d = debt_q - 1'b1;
        end
    end

    always_comb begin
        rgb_d = '0;
        if (kind == SLOT_SHOW) begin
            rgb_d = unpack_rgb(data_fifo_rd_data, 2'd0);
        end else if (active && frame_en && show_q && (lane != 2'd0)) begin
            rgb_d = unpack_rgb(pix_word_q, lane);
        end
    end

    // Pop is combinational on the counters, which sit at 0,0 during reset; keep it quiet there.
    assign vga_rd_valid = pop && vga_reset_n;

    always_ff @(posedge vga_clk or negedge vga_reset_n) begin
        if (!vga_reset_n) begin
            frame_en_q  <= 1'b0;
            debt_q      <= '0;
            pix_word_q  <= '0;
            show_q      <= 1'b0;
            underflow_q <= 1'b0;
            rgb_q       <= '0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            blank_n_q   <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            frame_en_q  <= frame_en;
            debt_q      <= debt_d;
            if (kind == SLOT_SHOW) pix_word_q <= data_fifo_rd_data;
            if (slot) show_q <= (kind == SLOT_SHOW);
            underflow_q <= uf_set || (underflow_q && !underflow_clr);
            rgb_q       <= rgb_d;
            hs_q        <= hs;
            vs_q        <= vs;
            blank_n_q   <= active;
            fs_q        <= fs;
        end
    end

    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign frame_start = fs_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_pixel_stream.sv
// Directed bench for vga_pixel_stream on an 8x2 raster (14x5 totals, 70-cycle frame).
// A show-ahead FIFO model feeds the DUT; expected pins are hand-derived per raster index.
module tb_vga_pixel_stream;

    logic         vga_clk = 1'b0;
    logic         vga_reset_n;
    logic         stream_en;
    logic         data_fifo_empty;
    logic [127:0] data_fifo_rd_data;
    logic         vga_rd_valid;
    logic [7:0]   vga_r, vga_g, vga_b;
    logic         vga_hs, vga_vs, vga_blank_n, frame_start, underflow;
    logic         underflow_clr;

    int unsigned  vectors = 0;
    int unsigned  miscompares = 0;
    int unsigned  pops = 0;
    int           pix = -1;

    logic [127:0] fifo_q[$];

    localparam logic [127:0] WORD_A = 128'h00AABBCC_00112233_00445566_00778899;
    localparam logic [127:0] WORD_B = 128'h00DDEEFF_00CCBBAA_00123456_00654321;
    localparam logic [127:0] WORD_C = 128'h00C3C3C3_00C2C2C2_00C1C1C1_00C0C0C0;
    localparam logic [127:0] WORD_D = 128'h00D3D3D3_00D2D2D2_00D1D1D1_00D0D0D0;
    localparam logic [127:0] WORD_E = 128'h00E3E3E3_00E2E2E2_00E1E1E1_00E0E0E0;
    localparam logic [127:0] WORD_F = 128'h00F3F3F3_00F2F2F2_00F1F1F1_00F0F0F0;
    localparam logic [127:0] WORD_G = 128'h00636363_00626262_00616161_00606060;
    localparam logic [127:0] WORD_X = 128'h00ABCDEF_00FEDCBA_00135790_00246800;

    always #5 vga_clk = ~vga_clk;

    vga_pixel_stream #(
        .IMAGE_WIDTH  (8),
        .IMAGE_HEIGHT (2),
        .H_FRONT      (2),
        .H_SYNC       (2),
        .H_BACK       (2),
        .V_FRONT      (1),
        .V_SYNC       (1),
        .V_BACK       (1)
    ) dut (
        .vga_clk           (vga_clk),
        .vga_reset_n       (vga_reset_n),
        .stream_en         (stream_en),
        .data_fifo_empty   (data_fifo_empty),
        .data_fifo_rd_data (data_fifo_rd_data),
        .vga_rd_valid      (vga_rd_valid),
        .vga_r             (vga_r),
        .vga_g             (vga_g),
        .vga_b             (vga_b),
        .vga_hs            (vga_hs),
        .vga_vs            (vga_vs),
        .vga_blank_n       (vga_blank_n),
        .frame_start       (frame_start),
        .underflow         (underflow),
        .underflow_clr     (underflow_clr)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @pix %0d: got %0h expected %0h", tag, pix, got, exp);
        end
    endtask

    function automatic logic [23:0] rgb();
        return {vga_r, vga_g, vga_b};
    endfunction

    task automatic fifo_sync();
        data_fifo_empty   = (fifo_q.size() == 0);
        data_fifo_rd_data = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [127:0] w);
        fifo_q.push_back(w);
        fifo_sync();
    endtask

    // Advance to the negedge where the registered pins show raster index s.
    task automatic go(input int s);
        while (pix < s) begin
            @(negedge vga_clk);
            pix++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rgb"}, 128'(rgb()), 128'h0);
        check({tag, "_sync"}, 128'({vga_hs, vga_vs, vga_blank_n, frame_start}), 128'h0);
        check({tag, "_uf"}, 128'(underflow), 128'h0);
        check({tag, "_rdv"}, 128'(vga_rd_valid), 128'h0);
    endtask

    // FIFO model: pop sampled just before the edge, applied just after it.
    initial begin
        logic p;
        forever begin
            @(negedge vga_clk);
            #4;
            p = vga_rd_valid;
            @(posedge vga_clk);
            #1;
            if (p) begin
                check("pop_nonempty", 128'(data_fifo_empty), 128'h0);
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
                pops++;
                fifo_sync();
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vga_reset_n   = 1'b0;
        stream_en     = 1'b1;
        underflow_clr = 1'b0;
        fifo_sync();
        push(WORD_A); push(WORD_B); push(WORD_A); push(WORD_B);
        repeat (3) @(negedge vga_clk);
        check_all_zero("reset");

        @(negedge vga_clk);
        vga_reset_n = 1'b1;
        pix = -1;

        // Raster timing and first frame of stream data
        go(0);  check("fs0", 128'(frame_start), 128'h1);
                check("blank0", 128'(vga_blank_n), 128'h1);
                check("pix0", 128'(rgb()), 128'h778899);
        go(1);  check("fs1", 128'(frame_start), 128'h0);
                check("pix1", 128'(rgb()), 128'h445566);
        go(2);  check("pix2", 128'(rgb()), 128'h112233);
        go(3);  check("pix3", 128'(rgb()), 128'hAABBCC);
        go(4);  check("pix4", 128'(rgb()), 128'h654321);
        go(7);  check("pix7", 128'(rgb()), 128'hDDEEFF);
        go(8);  check("blank8", 128'(vga_blank_n), 128'h0);
                check("pix8", 128'(rgb()), 128'h0);
        go(9);  check("hs9", 128'(vga_hs), 128'h0);
        go(10); check("hs10", 128'(vga_hs), 128'h1);
        go(11); check("hs11", 128'(vga_hs), 128'h1);
        go(12); check("hs12", 128'(vga_hs), 128'h0);
        go(14); check("pix14", 128'(rgb()), 128'h778899);
        go(18); check("pix18", 128'(rgb()), 128'h654321);
        go(40); push(WORD_C);
        go(41); check("vs41", 128'(vga_vs), 128'h0);
        go(42); check("vs42", 128'(vga_vs), 128'h1);
        go(56); check("vs56", 128'(vga_vs), 128'h0);
        go(69); check("pops_f0", 128'(pops), 128'd4);
                check("uf_f0", 128'(underflow), 128'h0);

        // Underflow at the second slot, discard of the owed word, realignment
        go(70); check("fs70", 128'(frame_start), 128'h1);
                check("pix70", 128'(rgb()), 128'hC0C0C0);
        go(71); check("pix71", 128'(rgb()), 128'hC1C1C1);
        go(73); check("uf73", 128'(underflow), 128'h0);
                underflow_clr = 1'b1;
        go(74); underflow_clr = 1'b0;
                check("uf74_set_wins", 128'(underflow), 128'h1);
                check("pix74", 128'(rgb()), 128'h0);
                check("blank74", 128'(vga_blank_n), 128'h1);
                push(WORD_D);
        go(75); check("pix75", 128'(rgb()), 128'h0);
        go(77); check("pix77", 128'(rgb()), 128'h0);
        go(78); check("pops_discard", 128'(pops), 128'd6);
                push(WORD_E);
        go(80); check("uf80", 128'(underflow), 128'h1);
                underflow_clr = 1'b1;
        go(81); underflow_clr = 1'b0;
                check("uf81_cleared", 128'(underflow), 128'h0);
        go(83); check("fifo_hold", 128'(fifo_q.size()), 128'd1);
        go(84); check("pix84", 128'(rgb()), 128'hE0E0E0);
                push(WORD_F);
        go(85); check("pix85", 128'(rgb()), 128'hE1E1E1);
        go(88); check("pix88", 128'(rgb()), 128'hF0F0F0);
        go(91); check("pix91", 128'(rgb()), 128'hF3F3F3);
        go(100); stream_en = 1'b0;
                 push(WORD_G);
        go(139); check("pops_f1", 128'(pops), 128'd8);

        // Disabled frame; a mid-frame stream_en pulse is ignored
        go(140); check("fs140", 128'(frame_start), 128'h1);
                 check("blank140", 128'(vga_blank_n), 128'h1);
                 check("pix140", 128'(rgb()), 128'h0);
        go(143); stream_en = 1'b1;
        go(144); stream_en = 1'b0;
                 check("pix144", 128'(rgb()), 128'h0);
        go(145); check("pix145", 128'(rgb()), 128'h0);
        go(154); check("pix154", 128'(rgb()), 128'h0);
                 check("blank154", 128'(vga_blank_n), 128'h1);
        go(200); stream_en = 1'b1;
        go(209); check("pops_f2", 128'(pops), 128'd8);
                 check("uf_f2", 128'(underflow), 128'h0);
                 check("fifo_f2", 128'(fifo_q.size()), 128'd1);

        // Build up debt of 3, then reset mid-line
        go(210); check("pix210", 128'(rgb()), 128'h606060);
        go(214); check("pix214", 128'(rgb()), 128'h0);
                 check("uf214", 128'(underflow), 128'h1);
        go(228); check("pix228", 128'(rgb()), 128'h0);
        go(239); check("pops_f3", 128'(pops), 128'd9);
                 vga_reset_n = 1'b0;
                 push(WORD_X);
                 #1;
                 check_all_zero("midreset");
        repeat (2) @(negedge vga_clk);
        check_all_zero("midreset_hold");
        vga_reset_n = 1'b1;
        pix = -1;

        go(0);  check("fs_rst", 128'(frame_start), 128'h1);
                check("pix_rst0", 128'(rgb()), 128'h246800);
        go(1);  check("pix_rst1", 128'(rgb()), 128'h135790);
                check("pops_rst", 128'(pops), 128'd10);
                check("uf_rst", 128'(underflow), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
